rsa_modexp: RTL
===============

RSA_MODEXP -- requirements
Module: rsa_modexp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the prime width; all key, message and result words SHALL be 2*WIDTH bits (K).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a one-cycle request strobe.
REQ-005 The block SHALL have port IN_N, input, K bits: the modulus (P*Q).
REQ-006 The block SHALL have port IN_EXP, input, K bits: the exponent (E to encrypt, D to decrypt).
REQ-007 The block SHALL have port IN_M, input, K bits: the message or ciphertext.
REQ-008 The block SHALL have port out_valid, output, 1 bit: a one-cycle result strobe.
REQ-009 The block SHALL have port OUT_C, output, K bits: the result, (IN_M ^ IN_EXP) mod IN_N.

Function
REQ-010 While IDLE, the block SHALL capture IN_N, IN_EXP and IN_M on the rising edge at which in_valid=1, then enter CALC.
REQ-011 States SHALL be IDLE, CALC and OUT; the transitions SHALL be IDLE->CALC on in_valid, CALC->OUT after K*K cycles, and OUT->IDLE after 1 cycle.
REQ-012 CALC SHALL use right-to-left square-and-multiply over all K exponent bits, LSB first, with R initialised to 1 and B initialised to IN_M.
REQ-013 For each exponent bit, CALC SHALL compute B*B mod N and R*B mod N concurrently over K cycles; R SHALL be updated only when the bit is 1, and B SHALL always be updated.
REQ-014 Latency SHALL be fixed and independent of the data: out_valid SHALL rise on the (K*K+1)th rising edge after the edge that captured the request (37 cycles for WIDTH=3).
REQ-015 out_valid SHALL be high for exactly one cycle; OUT_C SHALL carry the result in that cycle and SHALL be 0 in every other cycle.
REQ-016 The block SHALL ignore in_valid while in CALC or OUT, with no queuing, and SHALL accept a new request in the first IDLE cycle after OUT.
REQ-017 If IN_EXP=0 and IN_N>=2, the result SHALL be 1.
REQ-018 If IN_N<2, the result SHALL be 0; the full latency SHALL still be spent.
REQ-019 If IN_M>=IN_N, the result SHALL be 0; the full latency SHALL still be spent.
REQ-020 All intermediate values SHALL stay below N; no intermediate value SHALL exceed K+2 bits.

Reset
REQ-021 While rst_n=0, the state SHALL be IDLE, out_valid SHALL be 0, OUT_C SHALL be 0, and all datapath registers SHALL be 0.
REQ-022 Reset asserted mid-CALC or during OUT SHALL abort the operation with no out_valid; after release, the block SHALL be ready in IDLE on the first edge.

Configuration
REQ-023 With macro RSA_MODEXP_ERR_EN defined, the block SHALL add output port OUT_ERR (1 bit), asserted together with out_valid when IN_N<2 or IN_M>=IN_N, and 0 at all other times, including during reset.
REQ-024 Without RSA_MODEXP_ERR_EN, the block SHALL have no OUT_ERR port, and the behaviour of REQ-018 and REQ-019 SHALL be unchanged.

Structure
REQ-025 Package rsa_pkg SHALL hold the default WIDTH, the derived K, the state enum (IDLE, CALC, OUT) and the CALC cycle count K*K.
REQ-026 Sub-module rsa_modmul SHALL be instantiated twice (square and multiply).
REQ-027 rsa_modmul SHALL perform MSB-first interleaved modular multiplication, one multiplier bit per cycle over K cycles: acc = 2*acc + (bit ? a : 0), followed by at most two conditional subtractions of N.
REQ-028 rsa_modmul SHALL have a start input and operands a, b, n, and SHALL present its result on the cycle its done output is 1.

Verification
REQ-029 The bench SHALL apply N=33, EXP=3, M=4 and SHALL require out_valid after 37 cycles with OUT_C=31.
REQ-030 The bench SHALL apply N=33, EXP=7, M=31 and SHALL require OUT_C=4, the round-trip decrypt.
REQ-031 The bench SHALL apply N=33, EXP=0, M=5 and SHALL require OUT_C=1; it SHALL also apply N=1, EXP=5, M=0 and require OUT_C=0 (with OUT_ERR=1 when RSA_MODEXP_ERR_EN is defined).
REQ-032 The bench SHALL apply N=33, EXP=3, M=40 and SHALL require OUT_C=0, with OUT_ERR=1 when RSA_MODEXP_ERR_EN is defined.
REQ-033 The bench SHALL pulse in_valid again 5 cycles after a request and SHALL require that the pulse is ignored and that exactly one out_valid occurs, carrying the first result.
REQ-034 The bench SHALL drop rst_n at cycle 20 of CALC and SHALL require no out_valid and OUT_C=0; after release, the bench SHALL apply N=33, EXP=3, M=2 and require OUT_C=8.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared constants and FSM state type for the RSA modular exponentiator.
// Holds the default prime width, the derived word width and the CALC cycle count.
package rsa_pkg;

  localparam int WIDTH_DEF    = 3;
  localparam int K_DEF        = 2 * WIDTH_DEF;
  localparam int CALC_CYC_DEF = K_DEF * K_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic int calc_cycles(input int k);
    return k * k;
  endfunction

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved MSB-first modular multiplier a*b mod n, one bit of b per enabled cycle; result on o_done after K cycles.
// No backpressure: operands must be held stable while i_en is high; i_start clears the accumulator.
module rsa_modmul import rsa_pkg::*; #(
  parameter int K = K_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic         i_en,
  input  logic [K-1:0] i_a,
  input  logic [K-1:0] i_b,
  input  logic [K-1:0] i_n,
  output logic         o_done,
  output logic [K-1:0] o_res
);

  localparam int CW = $clog2(K);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  logic [CW-1:0] r_cnt;
  logic [K-1:0]  r_acc;
  logic          w_bit;
  logic [K+1:0]  w_n;
  logic [K+1:0]  w_sum;
  logic [K+1:0]  w_sub1;
  logic [K-1:0]  w_sub2;

  // acc < n and a < n keep 2*acc + a below 3n, so two subtractions always land below n.
  always_comb begin
    w_bit  = i_b[LAST - r_cnt];
    w_n    = {2'b00, i_n};
    w_sum  = {1'b0, r_acc, 1'b0} + (w_bit ? {2'b00, i_a} : '0);
    w_sub1 = (w_sum >= w_n) ? (w_sum - w_n) : w_sum;
    w_sub2 = (w_sub1 >= w_n) ? K'(w_sub1 - w_n) : K'(w_sub1);
    o_res  = w_sub2;
    o_done = i_en && (r_cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_start || o_done) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_acc <= w_sub2;
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rsa_modexp.sv
// Right-to-left square-and-multiply (M^EXP) mod N; fixed latency K*K+1 cycles from capture to out_valid.
// No backpressure: in_valid is ignored outside IDLE; optional OUT_ERR port under RSA_MODEXP_ERR_EN.
module rsa_modexp import rsa_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [2*WIDTH-1:0] IN_N,
  input  logic [2*WIDTH-1:0] IN_EXP,
  input  logic [2*WIDTH-1:0] IN_M,
`ifdef RSA_MODEXP_ERR_EN
  output logic               OUT_ERR,
`endif
  output logic               out_valid,
  output logic [2*WIDTH-1:0] OUT_C
);

  localparam int K    = 2 * WIDTH;
  localparam int CYC  = calc_cycles(K);
  localparam int CNTW = $clog2(CYC);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [K-1:0]    r_n;
  logic [K-1:0]    r_exp;
  logic [K-1:0]    r_b;
  logic [K-1:0]    r_r;
  logic            r_err;
  logic [CNTW-1:0] r_cnt;
  logic            r_out_valid;
  logic [K-1:0]    r_out_c;
  logic            w_start;
  logic            w_en;
  logic            w_in_err;
  logic            w_sq_done;
  logic            w_mul_done;
  logic [K-1:0]    w_sq_res;
  logic [K-1:0]    w_mul_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_en        = 1'b0;
    case (r_state)
      IDLE: begin
        w_start = in_valid;
        if (in_valid) w_state_nxt = CALC;
      end
      CALC: begin
        w_en = 1'b1;
        if (r_cnt == CNTW'(CYC - 1)) w_state_nxt = OUT;
      end
      OUT:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_in_err = (IN_N < K'(2)) || (IN_M >= IN_N);

  // Error cases zero R and B up front so they stay below N and the result falls out as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n   <= '0;
      r_exp <= '0;
      r_b   <= '0;
      r_r   <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (w_start) begin
      r_n   <= IN_N;
      r_exp <= IN_EXP;
      r_b   <= w_in_err ? '0 : IN_M;
      r_r   <= w_in_err ? '0 : K'(1);
      r_err <= w_in_err;
      r_cnt <= '0;
    end else if (w_en) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_sq_done && w_mul_done) begin
        r_b   <= w_sq_res;
        r_exp <= r_exp >> 1;
        if (r_exp[0]) r_r <= w_mul_res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_c     <= '0;
    end else begin
      r_out_valid <= (r_state == OUT);
      r_out_c     <= (r_state == OUT) ? r_r : '0;
    end
  end

  rsa_modmul #(.K(K)) u_sq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_en    (w_en),
    .i_a     (r_b),
    .i_b     (r_b),
    .i_n     (r_n),
    .o_done  (w_sq_done),
    .o_res   (w_sq_res)
  );

  rsa_modmul #(.K(K)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_en    (w_en),
    .i_a     (r_r),
    .i_b     (r_b),
    .i_n     (r_n),
    .o_done  (w_mul_done),
    .o_res   (w_mul_res)
  );

  assign out_valid = r_out_valid;
  assign OUT_C     = r_out_c;

`ifdef RSA_MODEXP_ERR_EN
  logic r_out_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_out_err <= 1'b0;
    else        r_out_err <= (r_state == OUT) && r_err;
  end

  assign OUT_ERR = r_out_err;
`endif

endmodule
